// File: rtl/chess_pkg.sv
// Shared chess encodings and square arithmetic for the king escape scheduler and its check detector.
package chess_pkg;

    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned BOARD_W   = 64 * NIBBLE_W;
    localparam int unsigned SQ_W      = 6;
    localparam int unsigned CHECK_LAT = 2;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    typedef enum logic [2:0] {
        PC_EMPTY  = 3'b000,
        PC_KING   = 3'b001,
        PC_QUEEN  = 3'b010,
        PC_BISHOP = 3'b011,
        PC_KNIGHT = 3'b100,
        PC_ROOK   = 3'b101,
        PC_PAWN   = 3'b110
    } piece_t;

    // Row step of king direction j (escape mask bit order: +1,-1,+8,-8,+9,+7,-7,-9).
    function automatic logic signed [1:0] dir_row(input logic [2:0] j);
        case (j)
            3'd0, 3'd1:       return 2'sd0;
            3'd2, 3'd4, 3'd5: return 2'sd1;
            default:          return -2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] dir_col(input logic [2:0] j);
        case (j)
            3'd0, 3'd4, 3'd6: return 2'sd1;
            3'd2, 3'd3:       return 2'sd0;
            default:          return -2'sd1;
        endcase
    endfunction

    // Row/column checked separately in 7-bit signed space so file wrap is caught.
    function automatic logic sq_on_board(input logic [SQ_W-1:0] pos,
                                         input logic signed [3:0] d_row,
                                         input logic signed [3:0] d_col);
        logic signed [6:0] r;
        logic signed [6:0] c;
        r = $signed({4'b0000, pos[5:3]}) + 7'(d_row);
        c = $signed({4'b0000, pos[2:0]}) + 7'(d_col);
        return (r >= 7'sd0) && (r <= 7'sd7) && (c >= 7'sd0) && (c <= 7'sd7);
    endfunction

    function automatic logic [SQ_W-1:0] sq_offset(input logic [SQ_W-1:0] pos,
                                                  input logic signed [3:0] d_row,
                                                  input logic signed [3:0] d_col);
        logic signed [6:0] s;
        s = $signed({1'b0, pos}) + 7'(d_row) * 7'sd8 + 7'(d_col);
        return SQ_W'(s);
    endfunction

endpackage

// File: rtl/king_escape_scheduler_checker.sv
// Check detector: reports whether the target square is attacked by the enemy colour.
// Two register stages give an in_check latency of CHECK_LAT cycles after stable inputs.
module king_escape_scheduler_checker
    import chess_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [BOARD_W-1:0] board,
    input  logic [SQ_W-1:0]    target,
    input  logic               enemy,
    output logic               in_check
);

    function automatic logic signed [3:0] knight_dr(input logic [2:0] i);
        case (i)
            3'd0, 3'd4: return 4'sd1;
            3'd1, 3'd5: return 4'sd2;
            3'd2, 3'd6: return -4'sd1;
            default:    return -4'sd2;
        endcase
    endfunction

    function automatic logic signed [3:0] knight_dc(input logic [2:0] i);
        case (i)
            3'd0, 3'd2: return 4'sd2;
            3'd1, 3'd3: return 4'sd1;
            3'd4, 3'd6: return -4'sd2;
            default:    return -4'sd1;
        endcase
    endfunction

    function automatic logic is_attacked(input logic [BOARD_W-1:0] b,
                                         input logic [SQ_W-1:0]    sq,
                                         input logic               foe);
        logic                  found;
        logic                  blocked;
        logic [NIBBLE_W-1:0]   nib;
        logic [SQ_W-1:0]       idx;
        logic signed [3:0]     dr;
        logic signed [3:0]     dc;
        found = 1'b0;
        // Knight jumps and adjacent enemy king
        for (int i = 0; i < 8; i++) begin
            dr = knight_dr(3'(i));
            dc = knight_dc(3'(i));
            if (sq_on_board(sq, dr, dc)) begin
                idx = sq_offset(sq, dr, dc);
                nib = b[{idx, 2'b00} +: NIBBLE_W];
                if (nib == {foe, PC_KNIGHT}) found = 1'b1;
            end
            dr = 4'(dir_row(3'(i)));
            dc = 4'(dir_col(3'(i)));
            if (sq_on_board(sq, dr, dc)) begin
                idx = sq_offset(sq, dr, dc);
                nib = b[{idx, 2'b00} +: NIBBLE_W];
                if (nib == {foe, PC_KING}) found = 1'b1;
            end
        end
        // Black pawns capture toward rank 1, so they attack from the row above
        dr = (foe == BLACK) ? 4'sd1 : -4'sd1;
        for (int i = 0; i < 2; i++) begin
            dc = (i == 0) ? 4'sd1 : -4'sd1;
            if (sq_on_board(sq, dr, dc)) begin
                idx = sq_offset(sq, dr, dc);
                nib = b[{idx, 2'b00} +: NIBBLE_W];
                if (nib == {foe, PC_PAWN}) found = 1'b1;
            end
        end
        // Sliders: the first occupied square along each ray decides
        for (int j = 0; j < 8; j++) begin
            blocked = 1'b0;
            for (int s = 1; s < 8; s++) begin
                dr = 4'(s) * 4'(dir_row(3'(j)));
                dc = 4'(s) * 4'(dir_col(3'(j)));
                if (!blocked && sq_on_board(sq, dr, dc)) begin
                    idx = sq_offset(sq, dr, dc);
                    nib = b[{idx, 2'b00} +: NIBBLE_W];
                    if (nib[2:0] != PC_EMPTY) begin
                        blocked = 1'b1;
                        if (nib[3] == foe &&
                            (nib[2:0] == PC_QUEEN ||
                             nib[2:0] == ((j < 4) ? PC_ROOK : PC_BISHOP)))
                            found = 1'b1;
                    end
                end
            end
        end
        return found;
    endfunction

    logic attack;
    logic attack_q;

    always_comb attack = is_attacked(board, target, enemy);

    always_ff @(posedge clk) begin
        if (reset) begin
            attack_q <= 1'b0;
            in_check <= 1'b0;
        end else begin
            attack_q <= attack;
            in_check <= attack_q;
        end
    end

endmodule

// File: rtl/king_escape_scheduler.sv
// Time-shares one check detector over the king square and its 8 neighbours,
// producing current-check, escape mask and mate/stalemate flags once per request.
module king_escape_scheduler
    import chess_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BOARD_W-1:0] bigBoard,
    input  logic [SQ_W-1:0]    kingPos,
    output logic               busy,
    output logic               done,
    output logic               inCheckNow,
    output logic [7:0]         escapeMask,
    output logic               checkmate,
    output logic               stalemate,
    output logic               badKing
);

    localparam int unsigned K_W   = 4;
    localparam int unsigned LAT_W = 2;

    typedef enum logic [2:0] {S_IDLE, S_VALIDATE, S_SEL, S_EVAL, S_FINISH} state_t;

    state_t              state;
    logic [BOARD_W-1:0]  board_q;
    logic [SQ_W-1:0]     pos_q;
    logic [NIBBLE_W-1:0] king_nib;
    logic [K_W-1:0]      k;
    logic [LAT_W-1:0]    lat_cnt;
    logic [BOARD_W-1:0]  chk_board;
    logic [SQ_W-1:0]     chk_target;
    logic                chk_in_check;

    logic [2:0]          cand_dir;
    logic                cand_on;
    logic [SQ_W-1:0]     cand_sq;
    logic [NIBBLE_W-1:0] cand_nib;
    logic                cand_eval;
    logic [BOARD_W-1:0]  hyp_board;

    king_escape_scheduler_checker u_checker (
        .clk      (clk),
        .reset    (reset),
        .board    (chk_board),
        .target   (chk_target),
        .enemy    (~king_nib[3]),
        .in_check (chk_in_check)
    );

    // Candidate k decode and hypothetical board with the king moved onto it
    always_comb begin
        cand_dir  = 3'(k - K_W'(1));
        cand_on   = sq_on_board(pos_q, 4'(dir_row(cand_dir)), 4'(dir_col(cand_dir)));
        cand_sq   = sq_offset(pos_q, 4'(dir_row(cand_dir)), 4'(dir_col(cand_dir)));
        cand_nib  = board_q[{cand_sq, 2'b00} +: NIBBLE_W];
        hyp_board = board_q;
        cand_eval = 1'b1;
        if (k != K_W'(0)) begin
            cand_eval = cand_on && !(cand_nib[2:0] != PC_EMPTY && cand_nib[3] == king_nib[3]);
            hyp_board[{pos_q, 2'b00} +: NIBBLE_W]   = '0;
            hyp_board[{cand_sq, 2'b00} +: NIBBLE_W] = king_nib;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            board_q    <= '0;
            pos_q      <= '0;
            king_nib   <= '0;
            k          <= '0;
            lat_cnt    <= '0;
            chk_board  <= '0;
            chk_target <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            inCheckNow <= 1'b0;
            escapeMask <= '0;
            checkmate  <= 1'b0;
            stalemate  <= 1'b0;
            badKing    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        board_q    <= bigBoard;
                        pos_q      <= kingPos;
                        king_nib   <= bigBoard[{kingPos, 2'b00} +: NIBBLE_W];
                        busy       <= 1'b1;
                        inCheckNow <= 1'b0;
                        escapeMask <= '0;
                        checkmate  <= 1'b0;
                        stalemate  <= 1'b0;
                        badKing    <= 1'b0;
                        state      <= S_VALIDATE;
                    end
                end
                S_VALIDATE: begin
                    k <= '0;
                    if (king_nib[2:0] != PC_KING) begin
                        badKing <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        state <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (cand_eval) begin
                        chk_board  <= hyp_board;
                        chk_target <= (k == K_W'(0)) ? pos_q : cand_sq;
                        lat_cnt    <= '0;
                        state      <= S_EVAL;
                    end else if (k == K_W'(8)) begin
                        state <= S_FINISH;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                S_EVAL: begin
                    if (lat_cnt == LAT_W'(CHECK_LAT)) begin
                        if (k == K_W'(0)) inCheckNow <= chk_in_check;
                        else              escapeMask[cand_dir] <= ~chk_in_check;
                        if (k == K_W'(8)) begin
                            state <= S_FINISH;
                        end else begin
                            k     <= k + K_W'(1);
                            state <= S_SEL;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_FINISH: begin
                    checkmate <= ~badKing & inCheckNow & ~|escapeMask;
                    stalemate <= ~badKing & ~inCheckNow & ~|escapeMask;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
